cam_frame_capture: RTL and testbench

Captures pixel data from the OV7670 camera's byte-serial RGB565 stream and writes a centre-cropped window into the dual-port frame buffer. The VGA image reader later reads that window back for display. The block sits between the camera pins (already registered in the camera pixel-clock domain) and the frame buffer's write port. It supports single-frame snapshot and continuous live capture.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_frame_capture_if.sv | 23 ++
 rtl/cam_sync_edge.sv | 22 ++
 rtl/cam_frame_capture.sv | 171 +++++++++++++++++
 tb/tb_cam_frame_capture.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the OV7670 frame capture block.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    localparam int DEF_SRC_WIDTH  = 320;
    localparam int DEF_SRC_HEIGHT = 240;
    localparam int DEF_IMG_WIDTH  = 176;
    localparam int DEF_IMG_HEIGHT = 240;

    // Left edge of the horizontally centred crop window.
    function automatic int crop_offset(input int src_w, input int img_w);
        return (src_w - img_w) / 2;
    endfunction

endpackage

// File: rtl/cam_frame_capture_if.sv
// Camera pin bundle plus frame-buffer write port for cam_frame_capture.
// we is a single-cycle valid with no ready/backpressure: the buffer must accept
// every pulse, and wAddr/wData hold their last values while we is low.
interface cam_frame_capture_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  cam_vsync;
    logic                  cam_href;
    logic [7:0]            cam_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [15:0]           wData;

    modport master (
        output cam_vsync, cam_href, cam_data,
        input  we, wAddr, wData
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data,
        output we, wAddr, wData
    );
endinterface

// File: rtl/cam_sync_edge.sv
// Registers a level and emits registered one-cycle rise/fall pulses.
module cam_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
            fall    <= ~level & level_q;
        end
    end
endmodule

// File: rtl/cam_frame_capture.sv
// Captures RGB565 byte pairs from the camera and writes a centre-cropped window
// into the frame buffer, in snapshot or continuous mode.
module cam_frame_capture
    import cam_pkg::*;
#(
    parameter int SRC_WIDTH  = DEF_SRC_WIDTH,
    parameter int SRC_HEIGHT = DEF_SRC_HEIGHT,
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 reset,
    cam_frame_capture_if.slave   bus,
    input  logic                 continuous,
    input  logic                 snap_req,
    output logic                 busy,
    output logic                 frame_done,
    output cap_state_e           state
);
    localparam int X_OFF = crop_offset(SRC_WIDTH, IMG_WIDTH);
    localparam int COL_W = $clog2(SRC_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

    localparam logic [COL_W-1:0]      X_LO    = COL_W'(X_OFF);
    localparam logic [COL_W-1:0]      X_HI    = COL_W'(X_OFF + IMG_WIDTH);
    localparam logic [COL_W-1:0]      COL_MAX = '1;
    localparam logic [ROW_W-1:0]      ROW_LIM = ROW_W'(IMG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_WIDTH);

    if (IMG_HEIGHT > SRC_HEIGHT || IMG_WIDTH > SRC_WIDTH) begin : g_bad_geometry
        $error("cam_frame_capture: stored image larger than camera image");
    end

    logic vsync_rise, vsync_fall;
    logic href_rise, href_fall;

    cam_sync_edge u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.cam_vsync),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    cam_sync_edge u_href_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.cam_href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    logic                  cap_start;
    logic                  phase;
    logic [7:0]            hi_byte;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  line_open;
    logic                  in_window;
    logic [COL_W-1:0]      crop_col;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [15:0]           wdata_q;

    assign cap_start = (state == ARM) && vsync_fall;
    assign in_window = (col >= X_LO) && (col < X_HI) && (row < ROW_LIM);
    assign crop_col  = col - X_LO;

    assign bus.we    = we_q;
    assign bus.wAddr = waddr_q;
    assign bus.wData = wdata_q;

    // Frame-level control: request arming, vsync framing, busy and frame_done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (continuous || snap_req) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (vsync_fall) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= continuous ? ARM : IDLE;
                        busy       <= continuous;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel assembly and crop addressing; the address is a running line base
    // plus the crop column, so a short line cannot shift the rows after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= 1'b0;
            hi_byte   <= '0;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            line_open <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (cap_start) begin
                phase     <= 1'b0;
                col       <= '0;
                row       <= '0;
                line_base <= '0;
                line_open <= 1'b0;
            end else if (state == CAPTURE) begin
                if (bus.cam_href) begin
                    if (!phase) begin
                        hi_byte <= bus.cam_data;
                        phase   <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (col != COL_MAX) begin
                            col <= col + COL_W'(1);
                        end
                        if (in_window) begin
                            we_q    <= 1'b1;
                            waddr_q <= line_base + ADDR_WIDTH'(crop_col);
                            wdata_q <= {hi_byte, bus.cam_data};
                        end
                    end
                end else begin
                    phase <= 1'b0;
                end

                if (href_rise) begin
                    line_open <= 1'b1;
                end

                // A trailing half pixel was already dropped by the phase clear.
                if (href_fall) begin
                    col       <= '0;
                    line_open <= 1'b0;
                    if (line_open && (row < ROW_LIM)) begin
                        row       <= row + ROW_W'(1);
                        line_base <= line_base + LINE_STEP;
                    end
                end
            end else begin
                phase     <= 1'b0;
                line_open <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_capture.sv
// Directed bench for cam_frame_capture: camera stream driver, per-cycle write
// scoreboard fed by a pixel-level crop model, and hand-computed anchor values.
module tb_cam_frame_capture;
    import cam_pkg::*;

    localparam int SRC_W = 320;
    localparam int SRC_H = 11;
    localparam int IMG_W = 176;
    localparam int IMG_H = 10;
    localparam int AW    = $clog2(IMG_W * IMG_H);
    localparam int X_OFF = (SRC_W - IMG_W) / 2;
    localparam int H_GAP = 8;
    localparam int V_HI  = 6;
    localparam int V_BP  = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       continuous;
    logic       snap_req;
    logic       busy;
    logic       frame_done;
    cap_state_e state;

    cam_frame_capture_if #(.ADDR_WIDTH(AW)) bus ();

    cam_frame_capture #(
        .SRC_WIDTH  (SRC_W),
        .SRC_HEIGHT (SRC_H),
        .IMG_WIDTH  (IMG_W),
        .IMG_HEIGHT (IMG_H),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .continuous (continuous),
        .snap_req   (snap_req),
        .busy       (busy),
        .frame_done (frame_done),
        .state      (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [AW+15:0] exp_q[$];
    int             tests = 0;
    int             fails = 0;
    int             writes_seen = 0;
    int             done_seen = 0;
    int             exp_done = 0;
    int             mark_cnt = -1;
    logic [AW-1:0]  mark_addr = '0;
    logic [15:0]    mark_data = '0;
    logic [AW-1:0]  last_addr = '0;
    logic [15:0]    last_data = '0;
    bit             prev_we = 1'b0;
    bit             armed = 1'b0;
    bit             cap_active = 1'b0;
    bit             exp_busy = 1'b0;
    int             frame_base = 0;
    int             frame_exp_writes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        logic [AW+15:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_addr = '0;
                last_data = '0;
                prev_we   = 1'b0;
            end else begin
                if (bus.we) begin
                    check("we_spacing", 32'(prev_we), 32'd0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %0d data 0x%04h expected no write",
                                 bus.wAddr, bus.wData);
                    end else begin
                        e = exp_q.pop_front();
                        check("wAddr", 32'(bus.wAddr), 32'(e[AW+15:16]));
                        check("wData", 32'(bus.wData), 32'(e[15:0]));
                    end
                    if (writes_seen == mark_cnt) begin
                        mark_addr = bus.wAddr;
                        mark_data = bus.wData;
                    end
                    writes_seen++;
                    last_addr = bus.wAddr;
                    last_data = bus.wData;
                end else begin
                    check("wAddr_hold", 32'(bus.wAddr), 32'(last_addr));
                    check("wData_hold", 32'(bus.wData), 32'(last_data));
                end
                prev_we = bus.we;
                if (frame_done) done_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one line; the model expects a write for every completed pixel
    // whose column falls inside the crop window of a captured, stored row.
    task automatic drive_line(input int row, input int nbytes, input int gap);
        int            c;
        logic [AW-1:0] a;
        for (int b = 0; b < nbytes; b++) begin
            c = b / 2;
            bus.cam_href = 1'b1;
            bus.cam_data = (b % 2 == 0) ? c[7:0] : row[7:0];
            if ((b % 2 == 1) && cap_active && (row < IMG_H) &&
                (c >= X_OFF) && (c < X_OFF + IMG_W)) begin
                a = AW'(row * IMG_W + c - X_OFF);
                exp_q.push_back({a, c[7:0], row[7:0]});
                frame_exp_writes++;
            end
            tick();
        end
        bus.cam_href = 1'b0;
        bus.cam_data = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic drive_frame();
        for (int r = 0; r < SRC_H; r++) drive_line(r, 2 * SRC_W, H_GAP);
    endtask

    task automatic snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        if (!exp_busy) begin
            armed    = 1'b1;
            exp_busy = 1'b1;
        end
        check("busy_after_snap", 32'(busy), 32'(exp_busy));
    endtask

    // Vertical blanking: the rising edge ends a captured frame, the falling
    // edge starts capture if a request is pending.
    task automatic vsync_pulse();
        bit fd_exp;
        fd_exp = cap_active;
        bus.cam_vsync = 1'b1;
        tick();
        check("frame_done_early", 32'(frame_done), 32'd0);
        tick();
        check("frame_done", 32'(frame_done), 32'(fd_exp));
        if (fd_exp) begin
            exp_done++;
            check("queue_drained", 32'(exp_q.size()), 32'd0);
            check("frame_writes", 32'(writes_seen - frame_base), 32'(frame_exp_writes));
            cap_active = 1'b0;
            armed      = continuous;
            exp_busy   = continuous;
        end
        check("busy_after_vsync", 32'(busy), 32'(exp_busy));
        repeat (V_HI - 2) tick();
        bus.cam_vsync = 1'b0;
        tick();
        tick();
        if (armed) begin
            cap_active       = 1'b1;
            frame_base       = writes_seen;
            frame_exp_writes = 0;
            mark_cnt         = writes_seen;
        end
        check("state_after_vfall", 32'(state),
              armed ? 32'(CAPTURE) : (exp_busy ? 32'(ARM) : 32'(IDLE)));
        repeat (V_BP) tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c0;
        reset         = 1'b0;
        continuous    = 1'b0;
        snap_req      = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        #2 reset = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_we", 32'(bus.we), 32'd0);
        check("rst_wAddr", 32'(bus.wAddr), 32'd0);
        check("rst_wData", 32'(bus.wData), 32'd0);
        check("rst_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Reset in the middle of a captured frame.
        snap();
        vsync_pulse();
        drive_line(0, 2 * SRC_W, H_GAP);
        drive_line(1, 2 * SRC_W, H_GAP);
        drive_line(2, 300, 0);
        check("we_before_reset", 32'(bus.we), 32'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        cap_active       = 1'b0;
        armed            = 1'b0;
        exp_busy         = 1'b0;
        frame_exp_writes = 0;
        #1;
        check("mid_rst_we", 32'(bus.we), 32'd0);
        check("mid_rst_wAddr", 32'(bus.wAddr), 32'd0);
        check("mid_rst_wData", 32'(bus.wData), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_state", 32'(state), 32'(IDLE));
        tick();
        reset = 1'b0;
        for (int r = 3; r < 6; r++) drive_line(r, 2 * SRC_W, H_GAP);
        vsync_pulse();
        for (int r = 0; r < 3; r++) drive_line(r, 2 * SRC_W, H_GAP);

        // Full snapshot frame; a second request during capture is ignored.
        snap();
        vsync_pulse();
        for (int r = 0; r < SRC_H; r++) begin
            drive_line(r, 2 * SRC_W, H_GAP);
            if (r == 3) snap();
        end
        check("snap_first_addr", 32'(mark_addr), 32'd0);
        check("snap_first_data", 32'(mark_data), 32'h4800);
        check("snap_last_addr", 32'(last_addr), 32'd1759);
        check("snap_last_data", 32'(last_data), 32'hF709);
        check("snap_count", 32'(writes_seen - frame_base), 32'd1760);
        vsync_pulse();
        check("snap_busy_low", 32'(busy), 32'd0);

        // Request in the middle of a frame: that frame is skipped.
        for (int r = 0; r < 5; r++) drive_line(r, 2 * SRC_W, H_GAP);
        snap();
        for (int r = 5; r < SRC_H; r++) drive_line(r, 2 * SRC_W, H_GAP);
        check("midreq_no_writes", 32'(writes_seen - frame_base), 32'd1760);
        vsync_pulse();
        drive_frame();
        check("midreq_first_addr", 32'(mark_addr), 32'd0);
        check("midreq_count", 32'(writes_seen - frame_base), 32'd1760);
        vsync_pulse();

        // Continuous mode over two frames, cleared during the second.
        c0 = done_seen;
        continuous = 1'b1;
        tick();
        armed    = 1'b1;
        exp_busy = 1'b1;
        check("cont_busy", 32'(busy), 32'd1);
        vsync_pulse();
        drive_frame();
        vsync_pulse();
        check("cont_busy_between", 32'(busy), 32'd1);
        for (int r = 0; r < SRC_H; r++) begin
            drive_line(r, 2 * SRC_W, H_GAP);
            if (r == 4) continuous = 1'b0;
        end
        check("cont_second_first_addr", 32'(mark_addr), 32'd0);
        check("cont_second_first_data", 32'(mark_data), 32'h4800);
        vsync_pulse();
        check("cont_done_pulses", 32'(done_seen - c0), 32'd2);
        check("cont_busy_end", 32'(busy), 32'd0);

        // Odd-byte line on row 3 and a short line on row 5.
        snap();
        vsync_pulse();
        for (int r = 0; r < 3; r++) drive_line(r, 2 * SRC_W, H_GAP);
        c0 = writes_seen;
        drive_line(3, 321, H_GAP);
        check("odd_row_writes", 32'(writes_seen - c0), 32'd88);
        mark_cnt = writes_seen;
        drive_line(4, 2 * SRC_W, H_GAP);
        check("after_odd_addr", 32'(mark_addr), 32'd704);
        check("after_odd_data", 32'(mark_data), 32'h4804);
        c0 = writes_seen;
        drive_line(5, 200, H_GAP);
        check("short_row_writes", 32'(writes_seen - c0), 32'd28);
        check("short_row_last_addr", 32'(last_addr), 32'd907);
        check("short_row_last_data", 32'(last_data), 32'h6305);
        mark_cnt = writes_seen;
        drive_line(6, 2 * SRC_W, H_GAP);
        check("after_short_addr", 32'(mark_addr), 32'd1056);
        check("after_short_data", 32'(mark_data), 32'h4806);
        for (int r = 7; r < SRC_H; r++) drive_line(r, 2 * SRC_W, H_GAP);
        check("odd_short_count", 32'(writes_seen - frame_base), 32'd1524);
        vsync_pulse();

        repeat (4) tick();
        check("total_frame_done", 32'(done_seen), 32'(exp_done));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
